// File: rtl/pdp8_pkg.sv
// ============================================================================
//  Module      : pdp8_pkg
//  Description : Shared PDP-8 decode types for the execution-unit responder.
//                Provides the decoded opcode structs, one-hot bit indices,
//                the responder state encoding and a latency helper.
//                Also supplies fallback global defines (ADDR_WIDTH,
//                DATA_WIDTH, START_ADDRESS) when none are set externally.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef START_ADDRESS
`define START_ADDRESS 12'o0100
`endif

package pdp8_pkg;

  // Memory-reference one-hot code bit positions
  localparam int MEM_JMP = 0;
  localparam int MEM_JMS = 1;
  localparam int MEM_DCA = 2;
  localparam int MEM_ISZ = 3;
  localparam int MEM_TAD = 4;
  localparam int MEM_AND = 5;

  // Operate (op7) one-hot bit positions
  localparam int OP7_CLA2 = 0;
  localparam int OP7_CLL  = 3;
  localparam int OP7_CMA  = 4;
  localparam int OP7_IAC  = 6;
  localparam int OP7_HLT  = 9;
  localparam int OP7_OSR  = 10;
  localparam int OP7_SKP  = 11;
  localparam int OP7_SNL  = 12;
  localparam int OP7_SZA  = 14;
  localparam int OP7_NOP  = 21;

  typedef struct packed {
    logic [5:0]             code;
    logic [`DATA_WIDTH-1:0] addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic [21:0] code;
  } pdp_op7_opcode_s;

  typedef enum logic [2:0] {
    LOAD = 3'd0,
    IDLE = 3'd1,
    BUSY = 3'd2,
    WCLR = 3'd3,
    HALT = 3'd4
  } exu_state_e;

  function automatic int lat_max(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exu_resp_bfm_timer.sv
// ============================================================================
//  Module      : exu_stall_timer
//  Description : Loadable down-counter that paces one command's busy time.
//                o_done is high while the count equals 1, i.e. during the
//                final busy cycle.
//  Ports       : clk, rst (async, active-high), i_load/i_load_val load the
//                count, i_dec decrements it, o_done flags count==1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exu_stall_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_done = (r_count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/exu_resp_bfm.sv
// ============================================================================
//  Module      : exu_resp_bfm
//  Description : Execution-unit responder model. Accepts decoded memory /
//                operate commands, holds stall for the command's latency,
//                tracks a modelled PC and flags decode-side protocol errors.
//  Ports       : clk, reset (async, active-high), base_addr (PC load value),
//                pdp_mem_opcode / pdp_op7_opcode (decoded command inputs),
//                stall, PC_value, cmd_count, halted, proto_err (outputs).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exu_resp_bfm
  import pdp8_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int JMP_LAT = 1,
  parameter int OP7_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [`ADDR_WIDTH-1:0] base_addr,
  input  pdp_mem_opcode_s        pdp_mem_opcode,
  input  pdp_op7_opcode_s        pdp_op7_opcode,
  output logic                   stall,
  output logic [`ADDR_WIDTH-1:0] PC_value,
  output logic [CNT_W-1:0]       cmd_count,
  output logic                   halted,
  output logic                   proto_err
);

  localparam int AW = `ADDR_WIDTH;
  localparam int TW = $clog2(lat_max(MEM_LAT, JMP_LAT, OP7_LAT)) + 1;

  exu_state_e      r_state;
  pdp_mem_opcode_s r_mem;
  pdp_op7_opcode_s r_op7;
  logic            r_nop;   // accepted command was malformed; runs as NOP
  logic            r_stall;
  logic [AW-1:0]   r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic            r_halted;
  logic            r_err;

  logic            w_mem_nz;
  logic            w_op7_nz;
  logic            w_accept;
  logic            w_bad;
  logic [TW-1:0]   w_lat;
  logic            w_done;
  logic [AW-1:0]   w_next_pc;

  assign w_mem_nz = |pdp_mem_opcode;
  assign w_op7_nz = |pdp_op7_opcode;
  assign w_accept = (r_state == IDLE) && (w_mem_nz || w_op7_nz);

  // A command is malformed if both structs carry something or the active
  // struct's code is not exactly one-hot (a zero code with a nonzero addr
  // counts as malformed too).
  assign w_bad = (w_mem_nz && w_op7_nz) ||
                 (w_mem_nz  && !$onehot(pdp_mem_opcode.code)) ||
                 (!w_mem_nz && !$onehot(pdp_op7_opcode.code));

  always_comb begin
    w_lat = TW'(OP7_LAT);
    if (!w_bad && w_mem_nz) begin
      w_lat = pdp_mem_opcode.code[MEM_JMP] ? TW'(JMP_LAT) : TW'(MEM_LAT);
    end
  end

  always_comb begin
    w_next_pc = r_pc + AW'(1);
    if (!r_nop) begin
      if (r_mem.code[MEM_JMP]) begin
        w_next_pc = r_mem.addr[AW-1:0];
      end else if (r_mem.code[MEM_JMS]) begin
        w_next_pc = r_mem.addr[AW-1:0] + AW'(1);
      end else if (r_op7.code[OP7_SKP]) begin
        w_next_pc = r_pc + AW'(2);
      end
    end
  end

  exu_stall_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_accept),
    .i_load_val (w_lat),
    .i_dec      (r_state == BUSY),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= LOAD;
      r_mem    <= '0;
      r_op7    <= '0;
      r_nop    <= 1'b0;
      r_stall  <= 1'b0;
      r_pc     <= `START_ADDRESS;
      r_cnt    <= '0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_pc    <= base_addr;
          r_state <= IDLE;
        end
        IDLE: begin
          if (w_accept) begin
            r_mem   <= pdp_mem_opcode;
            r_op7   <= pdp_op7_opcode;
            r_nop   <= w_bad;
            r_stall <= 1'b1;
            r_state <= BUSY;
            if (w_bad) r_err <= 1'b1;
          end
        end
        BUSY: begin
          // The driver must hold the command stable for the whole busy time
          if ((pdp_mem_opcode != r_mem) || (pdp_op7_opcode != r_op7)) begin
            r_err <= 1'b1;
          end
          if (w_done) begin
            r_pc  <= w_next_pc;
            r_cnt <= r_cnt + CNT_W'(1);
            if (!r_nop && r_op7.code[OP7_HLT]) begin
              r_halted <= 1'b1;
              r_state  <= HALT;
            end else begin
              r_stall <= 1'b0;
              r_state <= WCLR;
            end
          end
        end
        WCLR: begin
          // The held command must drop before anything new is accepted
          if (!w_mem_nz && !w_op7_nz) r_state <= IDLE;
        end
        HALT: begin
          r_state <= HALT;
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign stall     = r_stall;
  assign PC_value  = r_pc;
  assign cmd_count = r_cnt;
  assign halted    = r_halted;
  assign proto_err = r_err;

endmodule

`default_nettype wire
